mem_arbiter: RTL

Two-port arbiter and sequencer placed in front of the single-port word memory (`Memory`). It shares that memory between an instruction-fetch requester (port 0) and a load/store requester (port 1). Each transaction is a registered three-phase sequence that absorbs the memory's one-cycle registered read latency. Out-of-range addresses are rejected with an error flag rather than aliasing.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_select.sv | 23 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The address range helper is used by the arbiter when it latches a request.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

   localparam int ARB_RR      = 0;
   localparam int ARB_FIXED   = 1;

   localparam int PORT_IFETCH = 0;
   localparam int PORT_LSU    = 1;
   localparam int NUM_PORTS   = 2;

   // Unsigned compare against the byte size, done in 33 bits so a large memory cannot wrap.
   function automatic logic addr_oob(input logic [31:0] addr, input logic [31:0] mem_words);
      return {1'b0, addr} >= ({1'b0, mem_words} << 2);
   endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational two-way pick: a lone requester always wins, a tie is settled by mode.
// Output is don't-care when no port is requesting.
module mem_arb_select
   import mem_arb_pkg::*;
#(
   parameter int ARB_MODE = ARB_RR
) (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant
);

   always_comb begin
      grant = 1'b0;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = (ARB_MODE == ARB_FIXED) ? 1'b0 : ~last_grant;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port registered-read word memory between instruction fetch and load/store.
// Each access runs IDLE -> ISSUE -> RESP; every output is decoded from registered state.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEMORY_SIZE = 4096,
   parameter int ARB_MODE    = ARB_RR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_ack_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_ack_o,
   output logic [31:0] m1_rdata_o,
   output logic        err_o,
   output logic        mem_rd_en_o,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i
);

   localparam logic [31:0] MEM_WORDS = 32'(MEMORY_SIZE);

   logic [1:0]  req;
   logic        we_in    [NUM_PORTS];
   logic [31:0] addr_in  [NUM_PORTS];
   logic [31:0] wdata_in [NUM_PORTS];
   logic        ack_vec  [NUM_PORTS];
   logic [31:0] rdata_vec[NUM_PORTS];

   assign req[PORT_IFETCH]      = m0_req_i;
   assign req[PORT_LSU]         = m1_req_i;
   assign we_in[PORT_IFETCH]    = m0_we_i;
   assign we_in[PORT_LSU]       = m1_we_i;
   assign addr_in[PORT_IFETCH]  = m0_addr_i;
   assign addr_in[PORT_LSU]     = m1_addr_i;
   assign wdata_in[PORT_IFETCH] = m0_wdata_i;
   assign wdata_in[PORT_LSU]    = m1_wdata_i;

   arb_state_e  state_reg, state_next;
   logic        grant_reg, grant_next;
   logic        last_grant_reg, last_grant_next;
   logic        we_reg, we_next;
   logic        oob_reg, oob_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] wdata_reg, wdata_next;
   logic        sel_grant;

   mem_arb_select #(
      .ARB_MODE (ARB_MODE)
   ) u_select (
      .req        (req),
      .last_grant (last_grant_reg),
      .grant      (sel_grant)
   );

   // last_grant resets to port 1 so that port 0 takes the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         grant_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         we_reg         <= 1'b0;
         oob_reg        <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         we_reg         <= we_next;
         oob_reg        <= oob_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      we_next         = we_reg;
      oob_next        = oob_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      case (state_reg)
         IDLE: begin
            if (|req) begin
               grant_next      = sel_grant;
               last_grant_next = sel_grant;
               we_next         = we_in[sel_grant];
               addr_next       = addr_in[sel_grant] & 32'hFFFF_FFFC;
               wdata_next      = wdata_in[sel_grant];
               oob_next        = addr_oob(addr_in[sel_grant], MEM_WORDS);
               state_next      = ISSUE;
            end
         end
         ISSUE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   logic issue_st;
   logic resp_st;

   assign issue_st    = (state_reg == ISSUE);
   assign resp_st     = (state_reg == RESP);

   // An out-of-range access never touches memory, so it cannot alias a low word.
   assign mem_rd_en_o = issue_st & ~we_reg & ~oob_reg;
   assign mem_wr_en_o = issue_st &  we_reg & ~oob_reg;
   assign mem_addr_o  = issue_st ? addr_reg  : '0;
   assign mem_data_o  = issue_st ? wdata_reg : '0;
   assign err_o       = resp_st & oob_reg;

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign ack_vec[gi]   = resp_st & (grant_reg == 1'(gi));
      assign rdata_vec[gi] = (ack_vec[gi] & ~we_reg & ~oob_reg) ? mem_data_i : '0;
   end

   assign m0_ack_o   = ack_vec[PORT_IFETCH];
   assign m1_ack_o   = ack_vec[PORT_LSU];
   assign m0_rdata_o = rdata_vec[PORT_IFETCH];
   assign m1_rdata_o = rdata_vec[PORT_LSU];

endmodule
